// File: rtl/store_pkg.sv
// Shared definitions for the store narrowing buffer: size codes and the per-entry lane payload.
// Combinational definitions only; no latency or backpressure of its own.
// Each FIFO entry holds a word address plus the lane payload below.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LANE_W = 36;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  function automatic int entry_w(input int aw);
    return aw + LANE_W;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Narrows register store data to replicated byte lanes and builds byte enables.
// Purely combinational, zero latency.
// No backpressure; the enclosing buffer decides when the result is used.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_data,
  output lane_t       o_lane,
  output logic        o_misaligned
);

  always_comb begin
    o_lane.wdata = i_data;
    o_lane.be    = 4'b1111;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_lane.wdata = {4{i_data[7:0]}};
        o_lane.be    = 4'b0001 << i_addr_lo;
      end
      SZ_HALF: begin
        o_lane.wdata = {2{i_data[15:0]}};
        o_lane.be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addr_lo[0];
      end
      // Size code 11 behaves exactly like a word store.
      default: begin
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store buffer: narrows SB/SH/SW at push time and queues entries for the data-memory port.
// Latency: an accepted store is visible on mem_* one cycle later at the earliest.
// Backpressure: in_ready = !full (no same-cycle bypass); head holds while mem_ready is low. Option: STORE_MISALIGN_TRAP_EN.
module store_narrow_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
`ifdef STORE_MISALIGN_TRAP_EN
  output logic                     misalign_err,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [AW-1:2] r_addr_mem [DEPTH];
  lane_t         r_lane_mem [DEPTH];

  lane_t w_lane;
  logic  w_misaligned;
  logic  w_accept;
  logic  w_push;
  logic  w_pop;

  store_lane_align u_align (
    .i_addr_lo    (in_addr[1:0]),
    .i_size       (in_size),
    .i_data       (in_data),
    .o_lane       (w_lane),
    .o_misaligned (w_misaligned)
  );

  assign in_ready  = (r_count != FULL_CNT);
  assign mem_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = mem_valid && mem_ready;

`ifdef STORE_MISALIGN_TRAP_EN
  logic r_misalign_err;

  // Misaligned requests are consumed by the handshake but never stored.
  assign w_push       = w_accept && !w_misaligned;
  assign misalign_err = r_misalign_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_accept && w_misaligned;
    end
  end
`else
  logic w_unused_misaligned;

  assign w_push              = w_accept;
  assign w_unused_misaligned = w_misaligned;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_addr_mem[r_wr_ptr] <= in_addr[AW-1:2];
      r_lane_mem[r_wr_ptr] <= w_lane;
    end
  end

  assign mem_addr  = mem_valid ? {r_addr_mem[r_rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_valid ? r_lane_mem[r_rd_ptr].wdata : 32'h0;
  assign mem_be    = mem_valid ? r_lane_mem[r_rd_ptr].be : 4'h0;
  assign count     = r_count;

endmodule
